// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operand width, iteration
// count, FSM encoding and the conditional two's-complement helper.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS);
   localparam int WORK_W    = 2 * DIV_WIDTH + 1;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ZERO = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Two's-complement negate when n is set; identity otherwise.
   function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 n);
      logic [DIV_WIDTH-1:0] r;
      if (n) begin
         r = ~v + DIV_WIDTH'(1);
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {remainder, quotient} working
// register: shift left, trial-subtract the divisor, keep it if non-negative.
module div_step
   import div_pkg::*;
(
   input  logic [WORK_W-1:0]    work_i,
   input  logic [DIV_WIDTH-1:0] divisor_i,
   output logic [WORK_W-1:0]    work_o
);

   logic [WORK_W-1:0]  shifted;
   logic [DIV_WIDTH:0] trial;

   // Trial subtraction on the upper 33 bits; a clear sign bit means it fits.
   always_comb begin
      shifted = work_i << 1;
      trial   = shifted[WORK_W-1:DIV_WIDTH] - {1'b0, divisor_i};
      if (!trial[DIV_WIDTH]) begin
         work_o = {trial, shifted[DIV_WIDTH-1:1], 1'b1};
      end else begin
         work_o = shifted;
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: captures operands from E, runs 32 restoring
// iterations, applies the sign fix-up and holds the {HI, LO} result.
module div_sequencer
   import div_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   signed_div,
   input  logic                   annul,
   input  logic [DIV_WIDTH-1:0]   opa,
   input  logic [DIV_WIDTH-1:0]   opb,
   output logic                   stall_div,
   output logic                   ready,
   output logic [2*DIV_WIDTH-1:0] result
);

   logic [1:0]             state_q,   state_d;
   logic [CNT_W-1:0]       cnt_q,     cnt_d;
   logic [WORK_W-1:0]      work_q,    work_d;
   logic [DIV_WIDTH-1:0]   divisor_q, divisor_d;
   logic                   q_neg_q,   q_neg_d;
   logic                   r_neg_q,   r_neg_d;
   logic [2*DIV_WIDTH-1:0] result_q,  result_d;
   logic [WORK_W-1:0]      step_out;
   logic                   a_neg;
   logic                   b_neg;

   div_step u_step (
      .work_i    (work_q),
      .divisor_i (divisor_q),
      .work_o    (step_out)
   );

   assign a_neg = signed_div & opa[DIV_WIDTH-1];
   assign b_neg = signed_div & opb[DIV_WIDTH-1];

   // Next-state, datapath capture and result update; annul overrides everything.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (start && !annul) begin
               divisor_d = neg_if(opb, b_neg);
               q_neg_d   = a_neg ^ b_neg;
               r_neg_d   = a_neg;
               cnt_d     = '0;
               // The ZERO path needs the raw dividend, not its magnitude.
               if (opb == '0) begin
                  state_d = S_ZERO;
                  work_d  = {{(DIV_WIDTH+1){1'b0}}, opa};
               end else begin
                  state_d = S_BUSY;
                  work_d  = {{(DIV_WIDTH+1){1'b0}}, neg_if(opa, a_neg)};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            work_d = step_out;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d  = S_DONE;
               result_d = {neg_if(step_out[2*DIV_WIDTH-1:DIV_WIDTH], r_neg_q),
                           neg_if(step_out[DIV_WIDTH-1:0], q_neg_q)};
            end else begin
               state_d = S_BUSY;
            end
         end
         S_ZERO: begin
            state_d  = S_DONE;
            result_d = {work_q[DIV_WIDTH-1:0], {DIV_WIDTH{1'b1}}};
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (annul) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end else begin
         state_d = state_d;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         result_q  <= result_d;
      end
   end

   assign stall_div = ~annul & (((state_q == S_IDLE) & start) |
                                (state_q == S_BUSY) | (state_q == S_ZERO));
   assign ready     = (state_q == S_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a table of divides with hand-computed
// results and latencies, plus annul, annul-vs-start and mid-divide reset cases.
module tb_div_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic        annul;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        stall_div;
   logic        ready;
   logic [63:0] result;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [63:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   div_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .annul      (annul),
      .opa        (opa),
      .opb        (opb),
      .stall_div  (stall_div),
      .ready      (ready),
      .result     (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue a divide, hold start until stall_div drops, scramble operands after
   // acceptance, then check latency, stall length, result and pulse width.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp_res, input int exp_lat, input string name);
      int          cyc;
      int          stalls;
      int          ready_cyc;
      logic        stall_s;
      logic [63:0] res_at_ready;
      @(posedge clk); #1;
      start = 1'b1; opa = a; opb = b; signed_div = sgn;
      cyc = 0; stalls = 0; ready_cyc = -1; res_at_ready = '0;
      while (ready_cyc < 0 && cyc < 100) begin
         @(negedge clk);
         stall_s = stall_div;
         if (stall_s) stalls++;
         if (ready) begin
            ready_cyc    = cyc;
            res_at_ready = result;
         end
         @(posedge clk); #1;
         if (!stall_s) start = 1'b0;
         opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
         cyc++;
      end
      start = 1'b0;
      check({name, "_ready_cycle"}, 64'(ready_cyc), 64'(exp_lat));
      check({name, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
      check({name, "_result"}, res_at_ready, exp_res);
      @(negedge clk);
      check({name, "_ready_one_cycle"}, {63'd0, ready}, 64'd0);
      check({name, "_result_hold"}, result, exp_res);
   endtask

   task automatic expect_no_ready(input string name, input int ncyc);
      int pulses;
      pulses = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      check({name, "_no_ready"}, 64'(pulses), 64'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; opa = '0; opb = '0;

      vecs[0] = '{32'd100,        32'd7,          1'b0, {32'h00000002, 32'h0000000E}, 33};
      vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
      vecs[2] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h00000000, 32'h80000000}, 33};
      vecs[3] = '{32'd5,          32'd0,          1'b0, {32'h00000005, 32'hFFFFFFFF}, 2};
      vecs[4] = '{32'd7,          32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD}, 33};
      vecs[5] = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, {32'hFFFFFFFF, 32'h00000003}, 33};
      vecs[6] = '{32'hFFFFFFFF,   32'd1,          1'b0, {32'h00000000, 32'hFFFFFFFF}, 33};
      vecs[7] = '{32'hFFFFFFF9,   32'd2,          1'b0, {32'h00000001, 32'h7FFFFFFC}, 33};
      vecs[8] = '{32'hFFFFFFF9,   32'd0,          1'b1, {32'hFFFFFFF9, 32'hFFFFFFFF}, 2};
      vecs[9] = '{32'd3,          32'd9,          1'b0, {32'h00000003, 32'h00000000}, 33};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", {63'd0, ready}, 64'd0);
      check("reset_stall", {63'd0, stall_div}, 64'd0);
      check("reset_result", result, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_res, vecs[i].exp_lat,
                 $sformatf("vec%0d", i));
      end

      // Annul in the 10th BUSY cycle of DIVU 100/7 (cycle T+10).
      @(posedge clk); #1;
      start = 1'b1; opa = 32'd100; opb = 32'd7; signed_div = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      check("annul_stall_same_cycle", {63'd0, stall_div}, 64'd0);
      @(posedge clk); #1;
      annul = 1'b0;
      @(negedge clk);
      check("annul_stall_next", {63'd0, stall_div}, 64'd0);
      check("annul_ready_next", {63'd0, ready}, 64'd0);
      expect_no_ready("annul", 40);
      check("annul_result_unchanged", result, vecs[9].exp_res);
      run_div(32'd9, 32'd3, 1'b0, {32'h00000000, 32'h00000003}, 33, "after_annul");

      // Annul together with start in IDLE: nothing is accepted.
      @(posedge clk); #1;
      start = 1'b1; annul = 1'b1; opa = 32'd50; opb = 32'd5; signed_div = 1'b0;
      @(negedge clk);
      check("annul_vs_start_stall", {63'd0, stall_div}, 64'd0);
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0;
      @(negedge clk);
      check("annul_vs_start_idle", {63'd0, stall_div}, 64'd0);
      expect_no_ready("annul_vs_start", 40);
      check("annul_vs_start_result", result, 64'h00000000_00000003);

      // Reset in the 5th BUSY cycle of DIVU 100/7 (cycle T+5).
      @(posedge clk); #1;
      start = 1'b1; opa = 32'd100; opb = 32'd7; signed_div = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ready", {63'd0, ready}, 64'd0);
      check("midrst_stall", {63'd0, stall_div}, 64'd0);
      check("midrst_result", result, 64'd0);
      expect_no_ready("midrst", 40);
      check("midrst_result_hold", result, 64'd0);
      run_div(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E}, 33, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports named clk and rst as elsewhere in the codebase.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  E-stage divide request (DIV/DIVU in E, not flushed).
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 annul  input  1  abort current or pending divide (pipeline flush).
REQ-007 opa  input  32  dividend (forwarded rs).
REQ-008 opb  input  32  divisor (forwarded rt).
REQ-009 stall_div  output  1  to hazard unit; freezes F/D/E while divide is in flight.
REQ-010 ready  output  1  one-cycle pulse; result valid.
REQ-011 result  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.

Function
REQ-012 States SHALL be IDLE, BUSY, ZERO and DONE.
REQ-013 IDLE: start=1 and annul=0 -> capture opa, opb and signed_div; opb==0 -> ZERO, else BUSY with iteration counter=0.
REQ-014 BUSY: one restoring shift-subtract step per cycle on a 65-bit working register; counter increments; counter==31 -> DONE.
REQ-015 ZERO: one cycle -> DONE; result quotient=0xFFFFFFFF, remainder=captured dividend (unsigned and signed alike).
REQ-016 DONE: ready=1 for exactly one cycle; next state IDLE regardless of start.
REQ-017 stall_div = ~annul & ((IDLE & start) | BUSY | ZERO); 0 in DONE.
REQ-018 Latency: start accepted in cycle T -> stall_div high T..T+32, ready in T+33; divide-by-zero: ready in T+2.
REQ-019 Signed mode: divide magnitudes; negate quotient if operand signs differ; remainder takes dividend sign.
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (32-bit wrap, no trap).
REQ-021 Operands SHALL be sampled only on acceptance; opa/opb/signed_div changes during BUSY/ZERO are ignored.
REQ-022 start is ignored in BUSY, ZERO and DONE; a new divide is accepted only from IDLE.
REQ-023 annul=1 in any state -> IDLE next cycle, no ready pulse, result unchanged; annul wins over a simultaneous start.
REQ-024 result register SHALL hold its last value after DONE until the next completed divide.

Reset
REQ-025 On rst: state=IDLE, counter=0, working register=0, result=0, ready=0, stall_div=0 (when start=0); rst overrides annul and start.
REQ-026 rst asserted mid-BUSY SHALL abandon the operation with no ready pulse.

Structure
REQ-027 Shared package div_pkg SHALL hold the state encoding, DIV_WIDTH=32 and DIV_ITERS=32.
REQ-028 One combinational sub-module div_step SHALL implement a single shift-subtract iteration (65-bit in, 65-bit out); div_sequencer holds the FSM, counter, sign fix-up and result register.

Verification
REQ-029 DIVU opa=100, opb=7, start held until stall_div falls -> stall_div high 33 cycles, ready on 34th, result={0x00000002, 0x0000000E}.
REQ-030 DIV opa=0xFFFFFFF9 (-7), opb=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}.
REQ-031 DIV opa=0x80000000, opb=0xFFFFFFFF -> result={0x00000000, 0x80000000}, no stall beyond 33 cycles.
REQ-032 DIVU opa=5, opb=0 -> ZERO path, ready in T+2, result={0x00000005, 0xFFFFFFFF}.
REQ-033 DIVU 100/7 with annul pulsed in 10th BUSY cycle -> IDLE next cycle, no ready, stall_div low; following DIVU 9/3 -> result={0, 3} after 33 stall cycles.
REQ-034 rst asserted in 5th BUSY cycle -> all outputs at reset values next cycle, no ready pulse; subsequent divide completes normally.
